// File: rtl/m6502_bus_responder.sv
// M6502 data-bus responder: internal 2 KB RAM (mirrored through the RAM
// window) plus a downstream register/cartridge port. Reproduces the 6502
// read-modify-write dummy write so side-effect registers see read then write.

package M6502Defs;
  typedef enum logic [1:0] {
    Access_Read      = 2'd0,
    Access_Write     = 2'd1,
    Access_ReadWrite = 2'd2
  } AccessType;
endpackage

module m6502_bus_responder #(
  parameter int unsigned RAM_ADDR_BITS   = 11,
  parameter logic [15:0] RAM_WINDOW_END  = 16'h1FFF,
  parameter int unsigned RAM_WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [15:0]          i_req_addr,
  input  logic [7:0]           i_req_wdata,
  input  M6502Defs::AccessType i_req_access,
  output logic                 o_rsp_valid,
  output logic [7:0]           o_rsp_rdata,
  output logic                 o_ext_valid,
  input  logic                 i_ext_ready,
  output logic [15:0]          o_ext_addr,
  output logic                 o_ext_write,
  output logic [7:0]           o_ext_wdata,
  input  logic [7:0]           i_ext_rdata
);

  localparam int unsigned RAM_DEPTH  = 1 << RAM_ADDR_BITS;
  localparam logic [2:0]  LP_WAIT    = 3'(RAM_WAIT_STATES);
  localparam bit          LP_NO_WAIT = (RAM_WAIT_STATES == 0);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAM_WAIT  = 3'd1,
    ST_RAM_DUMMY = 3'd2,
    ST_EXT_RD    = 3'd3,
    ST_EXT_WR    = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  M6502Defs::AccessType       r_access;
  logic [RAM_ADDR_BITS-1:0]   r_ram_idx;
  logic [7:0]                 r_wdata;
  logic [2:0]                 r_wait_cnt;
  logic                       r_req_ready;
  logic                       r_rsp_valid;
  logic [7:0]                 r_rsp_rdata;
  logic                       r_ext_valid;
  logic                       r_ext_write;
  logic [15:0]                r_ext_addr;
  logic [7:0]                 r_ext_wdata;
  logic [7:0]                 r_mem [0:RAM_DEPTH-1];

  logic                       w_accept;
  logic                       w_req_is_ram;
  logic                       w_ext_hs;
  logic                       w_ram_done;
  logic                       w_ram_we;
  logic [7:0]                 w_ram_wdata;
  logic [7:0]                 w_ram_rdata;
  logic [RAM_ADDR_BITS-1:0]   w_ram_idx;
  M6502Defs::AccessType       w_cur_access;

  // r_req_ready is only ever set while in IDLE, so it doubles as the accept gate
  assign w_accept     = r_req_ready && i_req_valid;
  assign w_req_is_ram = (i_req_addr <= RAM_WINDOW_END);
  assign w_ext_hs     = r_ext_valid && i_ext_ready;
  assign w_ram_idx    = w_accept ? i_req_addr[RAM_ADDR_BITS-1:0] : r_ram_idx;
  assign w_cur_access = w_accept ? i_req_access : r_access;
  assign w_ram_rdata  = r_mem[w_ram_idx];

  // Next-state decode; w_ram_done marks the cycle the RAM access itself completes
  always_comb begin
    w_next     = r_state;
    w_ram_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_is_ram) begin
            if (LP_NO_WAIT) begin
              w_ram_done = 1'b1;
              w_next = (i_req_access == M6502Defs::Access_ReadWrite) ? ST_RAM_DUMMY : ST_RESP;
            end else begin
              w_next = ST_RAM_WAIT;
            end
          end else if (i_req_access == M6502Defs::Access_Write) begin
            w_next = ST_EXT_WR;
          end else begin
            w_next = ST_EXT_RD;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RAM_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_ram_done = 1'b1;
          w_next = (r_access == M6502Defs::Access_ReadWrite) ? ST_RAM_DUMMY : ST_RESP;
        end else begin
          w_next = ST_RAM_WAIT;
        end
      end
      ST_RAM_DUMMY: w_next = ST_RESP;
      ST_EXT_RD: begin
        if (w_ext_hs) begin
          w_next = (r_access == M6502Defs::Access_ReadWrite) ? ST_EXT_WR : ST_RESP;
        end else begin
          w_next = ST_EXT_RD;
        end
      end
      ST_EXT_WR: begin
        if (w_ext_hs) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_EXT_WR;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // RAM write port: real writes on completion, old-value rewrite in the dummy cycle
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_wdata = r_rsp_rdata;
    if (w_ram_done && (w_cur_access == M6502Defs::Access_Write)) begin
      w_ram_we    = 1'b1;
      w_ram_wdata = w_accept ? i_req_wdata : r_wdata;
    end else if (r_state == ST_RAM_DUMMY) begin
      w_ram_we    = 1'b1;
      w_ram_wdata = r_rsp_rdata;
    end else begin
      w_ram_we    = 1'b0;
    end
  end

  // RAM array: contents survive reset, but no write lands while reset is sampled
  always_ff @(posedge clk) begin
    if (w_ram_we && !reset) begin
      r_mem[w_ram_idx] <= w_ram_wdata;
    end
  end

  // State, request latches and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_access    <= M6502Defs::Access_Read;
      r_ram_idx   <= '0;
      r_wdata     <= 8'h00;
      r_wait_cnt  <= 3'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_ext_valid <= 1'b0;
      r_ext_write <= 1'b0;
      r_ext_addr  <= 16'h0000;
      r_ext_wdata <= 8'h00;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == ST_IDLE);
      r_rsp_valid <= (w_next == ST_RESP);
      // entering EXT_WR straight from EXT_RD leaves one idle cycle between phases
      r_ext_valid <= (w_next == ST_EXT_RD) || ((w_next == ST_EXT_WR) && (r_state != ST_EXT_RD));
      r_ext_write <= (w_next == ST_EXT_WR);
      if (w_accept) begin
        r_access   <= i_req_access;
        r_ram_idx  <= i_req_addr[RAM_ADDR_BITS-1:0];
        r_wdata    <= i_req_wdata;
        r_wait_cnt <= LP_WAIT - 3'd1;
        if (!w_req_is_ram) begin
          r_ext_addr  <= i_req_addr;
          r_ext_wdata <= i_req_wdata;
        end
      end else if (r_state == ST_RAM_WAIT) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (w_ram_done && (w_cur_access != M6502Defs::Access_Write)) begin
        r_rsp_rdata <= w_ram_rdata;
      end else if ((r_state == ST_EXT_RD) && w_ext_hs) begin
        r_rsp_rdata <= i_ext_rdata;
        r_ext_wdata <= i_ext_rdata;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_ext_valid = r_ext_valid;
  assign o_ext_addr  = r_ext_addr;
  assign o_ext_write = r_ext_write;
  assign o_ext_wdata = r_ext_wdata;

endmodule

// File: tb/tb_m6502_bus_responder.sv
// Directed bench for m6502_bus_responder: dut0 has no RAM wait states,
// dut1 has two. Inputs change on the falling edge, outputs are sampled there.

module tb_m6502_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic                 req_valid, req_ready, rsp_valid, ext_valid, ext_ready, ext_write;
  logic [15:0]          req_addr, ext_addr;
  logic [7:0]           req_wdata, rsp_rdata, ext_wdata, ext_rdata;
  M6502Defs::AccessType req_access;

  logic                 b_req_valid, b_req_ready, b_rsp_valid, b_ext_valid, b_ext_ready, b_ext_write;
  logic [15:0]          b_req_addr, b_ext_addr;
  logic [7:0]           b_req_wdata, b_rsp_rdata, b_ext_wdata, b_ext_rdata;
  M6502Defs::AccessType b_req_access;

  int n_pass   = 0;
  int n_checks = 0;
  int hs_cnt;

  m6502_bus_responder #(.RAM_ADDR_BITS(11), .RAM_WINDOW_END(16'h1FFF), .RAM_WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_access(req_access),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_ext_valid(ext_valid), .i_ext_ready(ext_ready), .o_ext_addr(ext_addr),
    .o_ext_write(ext_write), .o_ext_wdata(ext_wdata), .i_ext_rdata(ext_rdata)
  );

  m6502_bus_responder #(.RAM_ADDR_BITS(11), .RAM_WINDOW_END(16'h1FFF), .RAM_WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(reset),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
    .i_req_wdata(b_req_wdata), .i_req_access(b_req_access),
    .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata),
    .o_ext_valid(b_ext_valid), .i_ext_ready(b_ext_ready), .o_ext_addr(b_ext_addr),
    .o_ext_write(b_ext_write), .o_ext_wdata(b_ext_wdata), .i_ext_rdata(b_ext_rdata)
  );

  // Counts downstream handshakes on dut0
  always @(posedge clk) begin
    if (reset) hs_cnt <= 0;
    else if (ext_valid && ext_ready) hs_cnt <= hs_cnt + 1;
  end

  // Presents one request for one cycle (caller is at a falling edge with ready high);
  // returns at the falling edge of the cycle after acceptance
  task automatic issue(input bit sel, input logic [15:0] a, input M6502Defs::AccessType acc,
                       input logic [7:0] d);
    if (sel) begin
      b_req_valid = 1'b1; b_req_addr = a; b_req_access = acc; b_req_wdata = d;
    end else begin
      req_valid = 1'b1; req_addr = a; req_access = acc; req_wdata = d;
    end
    @(negedge clk);
    req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00; req_access = M6502Defs::Access_Read;
    b_req_valid = 1'b0; b_req_addr = 16'h0000; b_req_wdata = 8'h00; b_req_access = M6502Defs::Access_Read;
    ext_ready = 1'b0; ext_rdata = 8'h00; b_ext_ready = 1'b0; b_ext_rdata = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata got %h exp 00", rsp_rdata); else n_pass++;
    n_checks++; if ({ext_valid, ext_write} !== 2'b00) $display("FAIL rst_ext_ctl got %b%b exp 00", ext_valid, ext_write); else n_pass++;
    n_checks++; if ({ext_addr, ext_wdata} !== 24'h000000) $display("FAIL rst_ext_data got %h/%h exp 0000/00", ext_addr, ext_wdata); else n_pass++;
    n_checks++; if (b_req_ready !== 1'b0) $display("FAIL rst_b_req_ready got %b exp 0", b_req_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else n_pass++;
    n_checks++; if (b_req_ready !== 1'b1) $display("FAIL rst_release_b_ready got %b exp 1", b_req_ready); else n_pass++;
  endtask

  task automatic test_ram_mirror();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL mir_ready got %b exp 1", req_ready); else n_pass++;
    issue(1'b0, 16'h0012, M6502Defs::Access_Write, 8'h5A);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL mir_wr_rsp got %b exp 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL mir_wr_rdata_hold got %h exp 00", rsp_rdata); else n_pass++;
    n_checks++; if (ext_valid !== 1'b0) $display("FAIL mir_wr_no_ext got %b exp 0", ext_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL mir_after_rsp got %b%b exp 01", rsp_valid, req_ready); else n_pass++;
    issue(1'b0, 16'h0812, M6502Defs::Access_Read, 8'h00);
    n_checks++; if ({rsp_valid, rsp_rdata} !== 9'h15A) $display("FAIL mir_rd_0812 got %b/%h exp 1/5a", rsp_valid, rsp_rdata); else n_pass++;
    @(negedge clk);
    issue(1'b0, 16'h1812, M6502Defs::Access_Read, 8'h00);
    n_checks++; if ({rsp_valid, rsp_rdata} !== 9'h15A) $display("FAIL mir_rd_1812 got %b/%h exp 1/5a", rsp_valid, rsp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ext_read_stall();
    ext_ready = 1'b0; ext_rdata = 8'h80;
    issue(1'b0, 16'h2002, M6502Defs::Access_Read, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({ext_valid, ext_write, ext_addr, rsp_valid} !== {1'b1, 1'b0, 16'h2002, 1'b0})
        $display("FAIL extrd_stall%0d got v=%b w=%b a=%h rsp=%b exp v=1 w=0 a=2002 rsp=0", i, ext_valid, ext_write, ext_addr, rsp_valid);
      else n_pass++;
      if (i == 3) ext_ready = 1'b1;
      @(negedge clk);
    end
    ext_ready = 1'b0;
    n_checks++; if ({rsp_valid, rsp_rdata} !== 9'h180) $display("FAIL extrd_rsp got %b/%h exp 1/80", rsp_valid, rsp_rdata); else n_pass++;
    n_checks++; if (ext_valid !== 1'b0) $display("FAIL extrd_valid_drop got %b exp 0", ext_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_ext_rmw();
    int hs0;
    hs0 = hs_cnt;
    ext_ready = 1'b1; ext_rdata = 8'h33;
    issue(1'b0, 16'h4014, M6502Defs::Access_ReadWrite, 8'h00);
    n_checks++; if ({ext_valid, ext_write, ext_addr} !== {1'b1, 1'b0, 16'h4014}) $display("FAIL rmw_read_phase got v=%b w=%b a=%h exp v=1 w=0 a=4014", ext_valid, ext_write, ext_addr); else n_pass++;
    @(negedge clk);
    ext_rdata = 8'hEE;
    n_checks++; if ({ext_valid, rsp_valid} !== 2'b00) $display("FAIL rmw_gap got v=%b rsp=%b exp 0 0", ext_valid, rsp_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if ({ext_valid, ext_write, ext_addr, ext_wdata} !== {1'b1, 1'b1, 16'h4014, 8'h33}) $display("FAIL rmw_write_phase got v=%b w=%b a=%h d=%h exp v=1 w=1 a=4014 d=33", ext_valid, ext_write, ext_addr, ext_wdata); else n_pass++;
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_rdata, ext_valid} !== {1'b1, 8'h33, 1'b0}) $display("FAIL rmw_rsp got rsp=%b d=%h v=%b exp rsp=1 d=33 v=0", rsp_valid, rsp_rdata, ext_valid); else n_pass++;
    n_checks++; if ((hs_cnt - hs0) !== 2) $display("FAIL rmw_handshakes got %0d exp 2", hs_cnt - hs0); else n_pass++;
    ext_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [3:0] seen;
    n_checks++; if (b_req_ready !== 1'b1) $display("FAIL ws_ready got %b exp 1", b_req_ready); else n_pass++;
    issue(1'b1, 16'h07FF, M6502Defs::Access_Write, 8'hA5);
    seen = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      seen[i] = b_rsp_valid;
      if (i < 2) @(negedge clk);
    end
    n_checks++; if (seen[2:0] !== 3'b100) $display("FAIL ws_wr_timing got %b exp 100", seen[2:0]); else n_pass++;
    @(negedge clk);
    issue(1'b1, 16'h07FF, M6502Defs::Access_Read, 8'h00);
    seen = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      seen[i] = b_rsp_valid;
      if (i < 2) @(negedge clk);
    end
    n_checks++; if ({seen[2:0], b_rsp_rdata} !== {3'b100, 8'hA5}) $display("FAIL ws_rd got %b/%h exp 100/a5", seen[2:0], b_rsp_rdata); else n_pass++;
    @(negedge clk);
    issue(1'b1, 16'h07FF, M6502Defs::Access_ReadWrite, 8'h00);
    seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      seen[i] = b_rsp_valid;
      if (i < 3) @(negedge clk);
    end
    n_checks++; if ({seen, b_rsp_rdata} !== {4'b1000, 8'hA5}) $display("FAIL ws_rmw got %b/%h exp 1000/a5", seen, b_rsp_rdata); else n_pass++;
    @(negedge clk);
    issue(1'b1, 16'h07FF, M6502Defs::Access_Read, 8'h00);
    repeat (2) @(negedge clk);
    n_checks++; if ({b_rsp_valid, b_rsp_rdata, b_ext_valid} !== {1'b1, 8'hA5, 1'b0}) $display("FAIL ws_rmw_unchanged got %b/%h/%b exp 1/a5/0", b_rsp_valid, b_rsp_rdata, b_ext_valid); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_boundary();
    issue(1'b0, 16'h07FF, M6502Defs::Access_Write, 8'hC3);
    @(negedge clk);
    issue(1'b0, 16'h1FFF, M6502Defs::Access_Read, 8'h00);
    n_checks++; if ({rsp_valid, rsp_rdata, ext_valid} !== {1'b1, 8'hC3, 1'b0}) $display("FAIL bnd_1fff got %b/%h/%b exp 1/c3/0", rsp_valid, rsp_rdata, ext_valid); else n_pass++;
    @(negedge clk);
    ext_ready = 1'b1; ext_rdata = 8'h11;
    issue(1'b0, 16'h2000, M6502Defs::Access_Read, 8'h00);
    n_checks++; if ({ext_valid, ext_write, ext_addr} !== {1'b1, 1'b0, 16'h2000}) $display("FAIL bnd_2000_ext got v=%b w=%b a=%h exp v=1 w=0 a=2000", ext_valid, ext_write, ext_addr); else n_pass++;
    @(negedge clk);
    ext_ready = 1'b0;
    n_checks++; if ({rsp_valid, rsp_rdata} !== 9'h111) $display("FAIL bnd_2000_rsp got %b/%h exp 1/11", rsp_valid, rsp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    ext_ready = 1'b0;
    issue(1'b0, 16'h3000, M6502Defs::Access_Read, 8'h00);
    n_checks++; if (ext_valid !== 1'b1) $display("FAIL rmid_stalled got %b exp 1", ext_valid); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({ext_valid, rsp_valid, req_ready} !== 3'b000) $display("FAIL rmid_abandon got v=%b rsp=%b rdy=%b exp 0 0 0", ext_valid, rsp_valid, req_ready); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if ({req_ready, rsp_valid, ext_valid} !== 3'b100) $display("FAIL rmid_release got rdy=%b rsp=%b v=%b exp 1 0 0", req_ready, rsp_valid, ext_valid); else n_pass++;
    issue(1'b0, 16'h0012, M6502Defs::Access_Read, 8'h00);
    n_checks++; if ({rsp_valid, rsp_rdata} !== 9'h15A) $display("FAIL rmid_ram_kept got %b/%h exp 1/5a", rsp_valid, rsp_rdata); else n_pass++;
    @(negedge clk);
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ram_mirror();
    test_ext_read_stall();
    test_ext_rmw();
    test_wait_states();
    test_boundary();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
